seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scanner: double-buffered data, SHOW/GUARD slot timing, outputs registered one cycle behind state.
// Optional leading-zero blanking when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_ctrl #(
  parameter int SHOW_CYC  = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  output logic        load_ack,
  output logic [3:0]  num,
  output logic [3:0]  dig_en
);

  typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_GUARD} state_t;

  localparam int CMAX = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [15:0]   act_q, act_d;
  logic          load_ack_q, load_ack_d;
  logic [3:0]    num_q, num_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic          commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      pend_q     <= 16'h0;
      pend_v_q   <= 1'b0;
      act_q      <= 16'h0;
      load_ack_q <= 1'b0;
      num_q      <= 4'h0;
      dig_en_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      act_q      <= act_d;
      load_ack_q <= load_ack_d;
      num_q      <= num_d;
      dig_en_q   <= dig_en_d;
    end
  end

  // Next-state: en low forces OFF from anywhere; commit only on entry to digit 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
          commit  = pend_v_q;
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            commit  = pend_v_q && (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load on the commit edge lands in pend and keeps pend_v set for the next frame.
  always_comb begin
    pend_d     = load ? data : pend_q;
    pend_v_d   = load ? 1'b1 : (commit ? 1'b0 : pend_v_q);
    act_d      = commit ? pend_q : act_q;
    load_ack_d = load;
  end

  always_comb begin
    dig_en_d = 4'h0;
    num_d    = num_q;
    if (state_q == ST_SHOW) begin
      num_d    = act_q[{idx_q, 2'b00} +: 4];
      dig_en_d = 4'b0001 << idx_q;
`ifdef SEG_SCAN_LZ_BLANK_EN
      if ((idx_q != 2'd0) && ((act_q >> {idx_q, 2'b00}) == 16'h0))
        dig_en_d = 4'h0;
`endif
    end
  end

  assign load_ack = load_ack_q;
  assign num      = num_q;
  assign dig_en   = dig_en_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SHOW_CYC=4, GUARD_CYC=1 (20-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic        load_ack;
  logic [3:0]  num;
  logic [3:0]  dig_en;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  seg_scan_ctrl #(.SHOW_CYC(4), .GUARD_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .load_ack(load_ack), .num(num), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {dig_en,num} for the 20 samples of one frame showing value a.
  task automatic push_frame(input logic [15:0] a);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] nib;
      logic [3:0] oh;
      logic [15:0] hi;
      nib = 4'((a >> (4 * d)) & 16'hF);
      hi  = a >> (4 * d);
      oh  = 4'(1 << d);
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (d != 0 && hi == 16'h0) oh = 4'h0;
`endif
      for (int k = 0; k < 4; k++) exp_q.push_back({oh, nib});
      exp_q.push_back({4'h0, nib});
    end
  endtask

  // Reset, then release with en=1; first sample after this shows digit 0.
  task automatic start();
    exp_q.delete();
    rst = 1'b1; en = 1'b0; load = 1'b0; data = 16'h0;
    repeat (3) tick();
    rst = 1'b0; en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; load = 1'b1; data = 16'h9999;
    repeat (7) tick();
    rst = 1'b1; data = 16'hFFFF;
    repeat (3) tick();
    tests_run++;
    if (dig_en !== 4'h0) begin fails++; $display("FAIL reset_dig_en got %b want 0000", dig_en); end
    tests_run++;
    if (num !== 4'h0) begin fails++; $display("FAIL reset_num got %h want 0", num); end
    tests_run++;
    if (load_ack !== 1'b0) begin fails++; $display("FAIL reset_load_ack got %b want 0", load_ack); end
    rst = 1'b0; load = 1'b0;
    tick();
    tests_run++;
    if (dig_en !== 4'h0) begin fails++; $display("FAIL reset_first_cycle got %b want 0000", dig_en); end
    tests_run++;
    if (load_ack !== 1'b0) begin fails++; $display("FAIL reset_load_discard got %b want 0", load_ack); end
    tick();
    tests_run++;
    if (dig_en !== 4'b0001 || num !== 4'h0) begin
      fails++; $display("FAIL reset_second_cycle got %b/%h want 0001/0", dig_en, num);
    end
  endtask

  task automatic test_scan();
    start();
    push_frame(16'h0);
    push_frame(16'h0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e || !$onehot0(dig_en)) begin
        fails++; $display("FAIL scan[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    start();
    push_frame(16'h0);
    push_frame(16'h4321);
    data = 16'h4321;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      load = (i == 5);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e) begin
        fails++; $display("FAIL load_mid[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
      if (i == 5 || i == 6) begin
        tests_run++;
        if (load_ack !== (i == 5)) begin fails++; $display("FAIL load_mid_ack[%0d] got %b want %b", i, load_ack, (i == 5)); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    start();
    push_frame(16'h0);
    push_frame(16'h5555);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      load = (i == 3 || i == 4);
      data = (i == 3) ? 16'hAAAA : 16'h5555;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e) begin
        fails++; $display("FAIL b2b[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
      if (i >= 3 && i <= 5) begin
        tests_run++;
        if (load_ack !== (i != 5)) begin fails++; $display("FAIL b2b_ack[%0d] got %b want %b", i, load_ack, (i != 5)); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_en_drop();
    start();
    push_frame(16'h0);
    push_frame(16'h4321);
    while (exp_q.size() > 31) void'(exp_q.pop_back());
    exp_q.push_back({4'b0100, 4'h3});
    repeat (4) exp_q.push_back({4'b0000, 4'h3});
    push_frame(16'h4321);
    data = 16'h4321;
    for (int i = 0; i < 56; i++) begin
      logic [7:0] e;
      load = (i == 2);
      en = !(i >= 31 && i <= 34);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e) begin
        fails++; $display("FAIL en_drop[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
    end
    load = 1'b0; en = 1'b1;
  endtask

  task automatic test_commit_collision();
    start();
    push_frame(16'h0);
    push_frame(16'h1111);
    push_frame(16'h2222);
    for (int i = 0; i < 60; i++) begin
      logic [7:0] e;
      load = (i == 2 || i == 19);
      data = (i == 2) ? 16'h1111 : 16'h2222;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e) begin
        fails++; $display("FAIL collide[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
      if (i == 19) begin
        tests_run++;
        if (load_ack !== 1'b1) begin fails++; $display("FAIL collide_ack got %b want 1", load_ack); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_lz();
    start();
    push_frame(16'h0);
    push_frame(16'h0070);
    data = 16'h0070;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      load = (i == 2);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({dig_en, num} !== e) begin
        fails++; $display("FAIL lz[%0d] got %b/%h want %b/%h", i, dig_en, num, e[7:4], e[3:0]);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data = 16'h0;
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_back_to_back();
    test_en_drop();
    test_commit_collision();
    test_lz();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
